vscale_hazard_ctrl: RTL and testbench
=====================================

// Module: vscale_hazard_ctrl
// PURPOSE
//  Parametrised hazard/bypass controller for a multi-stage vscale integer pipe.
//  Tracks in-flight destination registers across NUM_STAGES post-DX stages plus one multi-cycle (MD) unit.
//  Produces per-source bypass selects and the DX stall, and drives writeback control.
//  Sits beside the main pipeline control decoder; the datapath muxes bypass data from sel'd stage.
// PARAMETERS
//  NUM_STAGES      2   post-DX stages; stage NUM_STAGES is WB (legal 1..7)
//  REG_ADDR_WIDTH  5   register address width
//  MD_LATENCY      4   cycles from MD issue to md_done (legal 1..255)
//  SEL_W = $clog2(NUM_STAGES+1) (localparam) bypass select width
// PORTS
//  clk            in   1              clock
//  reset          in   1              synchronous, active-high reset
//  issue_valid    in   1              DX holds a real instruction
//  kill_DX        in   1              DX instruction squashed this cycle
//  flush          in   1              exception/redirect flush of all tracked state
//  stall_in       in   1              downstream stall (dmem_wait); freezes stage shift
//  rs1_addr       in   REG_ADDR_WIDTH DX source 1
//  rs2_addr       in   REG_ADDR_WIDTH DX source 2
//  rs1_used       in   1              source 1 read by DX op
//  rs2_used       in   1              source 2 read by DX op
//  wr_reg_DX      in   1              DX op writes rd
//  rd_DX          in   REG_ADDR_WIDTH DX destination
//  wb_src_DX      in   2              0=ALU 1=MEM 2=MD (3 treated as ALU)
//  stall_DX       out  1              hold DX/IF this cycle
//  bypass_rs1_sel out  SEL_W          0=regfile, k=stage k result
//  bypass_rs2_sel out  SEL_W          as rs1
//  wr_reg_WB      out  1              pipeline writeback enable
//  reg_to_wr_WB   out  REG_ADDR_WIDTH pipeline writeback rd
//  wb_src_sel_WB  out  2              wb source of stage-NUM_STAGES entry
//  md_busy        out  1              MD unit occupied
//  md_done        out  1              one-cycle MD writeback strobe
//  md_rd          out  REG_ADDR_WIDTH MD destination
// BEHAVIOUR
//  - Entry e[k], k=1..NUM_STAGES: {valid, wr, rd, src}. issue = issue_valid & !kill_DX & !stall_DX.
//  - !stall_in: e[1]<=issue ? DX fields : bubble; e[k+1]<=e[k]. stall_in: all entries hold.
//  - MD ops enter the pipe with wr=0 (written via md port instead).
//  - Match(k,rs): used & e[k].valid & e[k].wr & e[k].rd==rs & rs!=0. Youngest (lowest k) match wins.
//  - Ready: ALU in any stage; MEM only at k=NUM_STAGES. Youngest match ready -> sel=k; else sel=0.
//  - Youngest match not ready (load-use) -> stall_DX.
//  - MD: issue with src=MD loads counter=MD_LATENCY, latches md_rd, md_busy=1. Counter decrements every
//    cycle regardless of stall_in; on 1->0 md_done=1 for one cycle, md_busy falls same cycle.
//  - MD conflict stall: md_busy & (DX is MD op | rs1/rs2 used ==md_rd!=0 | wr_reg_DX & rd_DX==md_rd).
//    Guarantees md_done never collides with a same-rd pipeline write; md_done cycle itself is not busy.
//  - stall_DX = stall_in | load-use | MD conflict. Combinational, no extra latency.
//  - wr_reg_WB = e[N].valid & e[N].wr & !stall_in; reg_to_wr_WB/wb_src_sel_WB = e[N] fields.
//  - flush (sync): all e[k].valid<=0, counter<=0, md_busy<=0, no md_done; has priority over stall_in and issue.
//  - reset: as flush; md_rd<=0, all entry fields 0. After reset: wr_reg_WB=0, md_busy=0, md_done=0, sels=0,
//    stall_DX=stall_in.
// CONFIGURATION
//  VSCALE_HAZARD_BYPASS_EN defined: bypass as above.
//  Undefined: bypass sels tied 0; any Match in any stage stalls DX until the writer leaves WB.
// TESTING
//  1 ALU add x5 then dependent add rs1=x5, NUM_STAGES=2 -> no stall, bypass_rs1_sel=1; next cycle sel 2 if reused.
//  2 load x6 then use rs2=x6 -> stall_DX for 1 cycle (2 stages), then bypass_rs2_sel=2; bypass off: stall until WB.
//  3 MD to x7 (MD_LATENCY=4), then read x7 -> stall 3 cycles, md_done in cycle 4 with md_rd=7, then sel=0.
//  4 writes to x0 followed by read of x0 -> never stall, sels stay 0, wr_reg_WB asserted per decode.
//  5 stall_in held 3 cycles with ALU in e[2] -> entries frozen, wr_reg_WB=0, MD counter still decrements.
//  6 flush during MD busy and full pipe -> next cycle md_busy=0, no md_done, all entries invalid, stall_DX=stall_in.

Source files
------------

// File: rtl/vscale_hazard_ctrl.sv
// vscale_hazard_ctrl: tracks in-flight destinations across the post-DX stages and the MD unit, and produces bypass selects, the DX stall and writeback control.
// Bypass selects are active only with `VSCALE_HAZARD_BYPASS_EN; otherwise any hazard stalls DX until the writer leaves WB.
module vscale_hazard_ctrl #(
    parameter int NUM_STAGES = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MD_LATENCY = 4,
    localparam int SEL_W = $clog2(NUM_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic                      kill_DX,
    input  logic                      flush,
    input  logic                      stall_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic                      rs1_used,
    input  logic                      rs2_used,
    input  logic                      wr_reg_DX,
    input  logic [REG_ADDR_WIDTH-1:0] rd_DX,
    input  logic [1:0]                wb_src_DX,
    output logic                      stall_DX,
    output logic [SEL_W-1:0]          bypass_rs1_sel,
    output logic [SEL_W-1:0]          bypass_rs2_sel,
    output logic                      wr_reg_WB,
    output logic [REG_ADDR_WIDTH-1:0] reg_to_wr_WB,
    output logic [1:0]                wb_src_sel_WB,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [REG_ADDR_WIDTH-1:0] md_rd
);
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_MD = 2'd2;

    logic [NUM_STAGES:1]       valid_q, valid_d, wr_q, wr_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q [1:NUM_STAGES];
    logic [REG_ADDR_WIDTH-1:0] rd_d [1:NUM_STAGES];
    logic [1:0]                src_q [1:NUM_STAGES];
    logic [1:0]                src_d [1:NUM_STAGES];
    logic [7:0]                cnt_q, cnt_d;
    logic [REG_ADDR_WIDTH-1:0] md_rd_q, md_rd_d;
    logic [SEL_W-1:0]          sel [2];
    logic [1:0]                hz;
    logic [1:0]                used;
    logic [REG_ADDR_WIDTH-1:0] rs [2];
    logic                      md_conf, is_md, issue;

    assign used = {rs2_used, rs1_used};
    assign rs[0] = rs1_addr;
    assign rs[1] = rs2_addr;
    assign is_md = wb_src_DX == SRC_MD;

    // Scan oldest to youngest so the youngest matching stage decides.
    always_comb begin
        sel = '{default: '0};
        hz = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (used[s] && valid_q[k] && wr_q[k] && rd_q[k] == rs[s] && rs[s] != '0) begin
`ifdef VSCALE_HAZARD_BYPASS_EN
                    sel[s] = (k == NUM_STAGES || src_q[k] != SRC_MEM) ? SEL_W'(k) : '0;
                    hz[s] = !(k == NUM_STAGES || src_q[k] != SRC_MEM);
`else
                    hz[s] = 1'b1;
`endif
                end
            end
        end
    end

    assign md_conf = md_busy & (is_md
                     | (rs1_used & rs1_addr == md_rd_q & md_rd_q != '0)
                     | (rs2_used & rs2_addr == md_rd_q & md_rd_q != '0)
                     | (wr_reg_DX & rd_DX == md_rd_q));
    assign stall_DX = stall_in | (|hz) | md_conf;
    assign issue = issue_valid & !kill_DX & !stall_DX;

    always_comb begin
        valid_d = valid_q;
        wr_d = wr_q;
        rd_d = rd_q;
        src_d = src_q;
        cnt_d = cnt_q != '0 ? cnt_q - 8'd1 : '0;
        md_rd_d = md_rd_q;
        if (!stall_in) begin
            valid_d[1] = issue;
            wr_d[1] = issue & wr_reg_DX & !is_md;
            rd_d[1] = rd_DX;
            src_d[1] = wb_src_DX;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                wr_d[k] = wr_q[k-1];
                rd_d[k] = rd_q[k-1];
                src_d[k] = src_q[k-1];
            end
        end
        if (issue && is_md) begin
            cnt_d = 8'(MD_LATENCY);
            md_rd_d = rd_DX;
        end
        if (flush) begin
            valid_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            wr_q <= '0;
            rd_q <= '{default: '0};
            src_q <= '{default: '0};
            cnt_q <= '0;
            md_rd_q <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            src_q <= src_d;
            cnt_q <= cnt_d;
            md_rd_q <= md_rd_d;
        end
    end

    assign bypass_rs1_sel = sel[0];
    assign bypass_rs2_sel = sel[1];
    assign wr_reg_WB = valid_q[NUM_STAGES] & wr_q[NUM_STAGES] & !stall_in;
    assign reg_to_wr_WB = rd_q[NUM_STAGES];
    assign wb_src_sel_WB = src_q[NUM_STAGES];
    assign md_busy = cnt_q > 8'd1;
    assign md_done = cnt_q == 8'd1 && !flush && !reset;
    assign md_rd = md_rd_q;
endmodule

// File: tb/tb_vscale_hazard_ctrl.sv
// tb_vscale_hazard_ctrl: directed checks of the hazard controller with default parameters (2 stages, MD latency 4).
module tb_vscale_hazard_ctrl;
`ifdef VSCALE_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic       clk, reset, issue_valid, kill_DX, flush, stall_in;
    logic [4:0] rs1_addr, rs2_addr, rd_DX, reg_to_wr_WB, md_rd;
    logic       rs1_used, rs2_used, wr_reg_DX, stall_DX, wr_reg_WB, md_busy, md_done;
    logic [1:0] wb_src_DX, wb_src_sel_WB, bypass_rs1_sel, bypass_rs2_sel;
    int         total = 0;
    int         bad = 0;

    vscale_hazard_ctrl dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .kill_DX(kill_DX), .flush(flush),
        .stall_in(stall_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used),
        .rs2_used(rs2_used), .wr_reg_DX(wr_reg_DX), .rd_DX(rd_DX), .wb_src_DX(wb_src_DX),
        .stall_DX(stall_DX), .bypass_rs1_sel(bypass_rs1_sel), .bypass_rs2_sel(bypass_rs2_sel),
        .wr_reg_WB(wr_reg_WB), .reg_to_wr_WB(reg_to_wr_WB), .wb_src_sel_WB(wb_src_sel_WB),
        .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic iv, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic w, input logic [4:0] rd, input logic [1:0] src);
        issue_valid = iv;
        kill_DX = 1'b0;
        rs1_addr = r1;
        rs1_used = u1;
        rs2_addr = r2;
        rs2_used = u2;
        wr_reg_DX = w;
        rd_DX = rd;
        wb_src_DX = src;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        stall_in = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        idle();
        chk("rst_wr_reg_WB", wr_reg_WB, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        chk("rst_sel1", bypass_rs1_sel, 0);
        chk("rst_sel2", bypass_rs2_sel, 0);
        chk("rst_stall", stall_DX, 0);
        stall_in = 1'b1;
        #1;
        chk("rst_stall_in", stall_DX, 1);
        stall_in = 1'b0;

        // ALU x5 then dependent reads of x5
        drv(1, 0, 0, 0, 0, 1, 5, 0);
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_b_stall", stall_DX, BYP ? 0 : 1);
        chk("alu_b_sel1", bypass_rs1_sel, BYP ? 1 : 0);
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_c_stall", stall_DX, BYP ? 0 : 1);
        chk("alu_c_sel1", bypass_rs1_sel, BYP ? 2 : 0);
        chk("alu_c_wr_wb", wr_reg_WB, 1);
        chk("alu_c_rd_wb", reg_to_wr_WB, 5);
        tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0);
        chk("alu_d_stall", stall_DX, 0);
        chk("alu_d_sel1", bypass_rs1_sel, 0);
        tick();
        idle();
        tick();
        tick();

        // load x6 then use on rs2
        drv(1, 0, 0, 0, 0, 1, 6, 1);
        tick();
        drv(1, 0, 0, 6, 1, 0, 0, 0);
        chk("ld_b_stall", stall_DX, 1);
        chk("ld_b_sel2", bypass_rs2_sel, 0);
        tick();
        drv(1, 0, 0, 6, 1, 0, 0, 0);
        chk("ld_c_stall", stall_DX, BYP ? 0 : 1);
        chk("ld_c_sel2", bypass_rs2_sel, BYP ? 2 : 0);
        chk("ld_c_wr_wb", wr_reg_WB, 1);
        chk("ld_c_rd_wb", reg_to_wr_WB, 6);
        chk("ld_c_src_wb", wb_src_sel_WB, 1);
        tick();
        drv(1, 0, 0, 6, 1, 0, 0, 0);
        chk("ld_d_stall", stall_DX, 0);
        chk("ld_d_sel2", bypass_rs2_sel, 0);
        tick();
        idle();
        tick();
        tick();

        // MD to x7 then read x7
        drv(1, 0, 0, 0, 0, 1, 7, 2);
        chk("md_issue_stall", stall_DX, 0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drv(1, 7, 1, 0, 0, 0, 0, 0);
            chk("md_wait_stall", stall_DX, 1);
            chk("md_wait_busy", md_busy, 1);
            chk("md_wait_done", md_done, 0);
            chk("md_wait_wr_wb", wr_reg_WB, 0);
            tick();
        end
        drv(1, 7, 1, 0, 0, 0, 0, 0);
        chk("md_done", md_done, 1);
        chk("md_done_rd", md_rd, 7);
        chk("md_done_busy", md_busy, 0);
        chk("md_done_stall", stall_DX, 0);
        chk("md_done_sel1", bypass_rs1_sel, 0);
        tick();
        idle();
        chk("md_after_done", md_done, 0);
        tick();
        tick();

        // x0 writes and reads never hazard
        drv(1, 0, 1, 0, 1, 1, 0, 0);
        chk("x0_a_stall", stall_DX, 0);
        tick();
        drv(1, 0, 1, 0, 1, 1, 0, 1);
        chk("x0_b_stall", stall_DX, 0);
        chk("x0_b_sel1", bypass_rs1_sel, 0);
        chk("x0_b_sel2", bypass_rs2_sel, 0);
        tick();
        drv(1, 0, 1, 0, 1, 0, 0, 0);
        chk("x0_c_stall", stall_DX, 0);
        chk("x0_c_sel2", bypass_rs2_sel, 0);
        chk("x0_c_wr_wb", wr_reg_WB, 1);
        chk("x0_c_rd_wb", reg_to_wr_WB, 0);
        tick();
        idle();
        tick();
        tick();

        // stall_in freezes the pipe while the MD counter keeps running
        drv(1, 0, 0, 0, 0, 1, 9, 2);
        tick();
        drv(1, 0, 0, 0, 0, 1, 10, 0);
        chk("si_alu_stall", stall_DX, 0);
        tick();
        idle();
        tick();
        stall_in = 1'b1;
        #1;
        chk("si1_stall", stall_DX, 1);
        chk("si1_wr_wb", wr_reg_WB, 0);
        chk("si1_rd_wb", reg_to_wr_WB, 10);
        chk("si1_busy", md_busy, 1);
        tick();
        chk("si2_done", md_done, 1);
        chk("si2_md_rd", md_rd, 9);
        chk("si2_wr_wb", wr_reg_WB, 0);
        chk("si2_rd_wb", reg_to_wr_WB, 10);
        tick();
        chk("si3_done", md_done, 0);
        chk("si3_wr_wb", wr_reg_WB, 0);
        chk("si3_rd_wb", reg_to_wr_WB, 10);
        tick();
        stall_in = 1'b0;
        #1;
        chk("si_rel_wr_wb", wr_reg_WB, 1);
        chk("si_rel_rd_wb", reg_to_wr_WB, 10);
        tick();
        chk("si_post_wr_wb", wr_reg_WB, 0);
        tick();

        // flush with MD busy and a full pipe
        drv(1, 0, 0, 0, 0, 1, 11, 2);
        tick();
        drv(1, 0, 0, 0, 0, 1, 12, 0);
        tick();
        drv(1, 0, 0, 0, 0, 1, 13, 0);
        chk("fl_pre_busy", md_busy, 1);
        tick();
        idle();
        flush = 1'b1;
        #1;
        chk("fl_cyc_wr_wb", wr_reg_WB, 1);
        tick();
        flush = 1'b0;
        stall_in = 1'b1;
        drv(1, 13, 1, 12, 1, 0, 0, 0);
        chk("fl_busy", md_busy, 0);
        chk("fl_done", md_done, 0);
        chk("fl_wr_wb", wr_reg_WB, 0);
        chk("fl_stall_in", stall_DX, 1);
        stall_in = 1'b0;
        #1;
        chk("fl_stall", stall_DX, 0);
        chk("fl_sel1", bypass_rs1_sel, 0);
        chk("fl_sel2", bypass_rs2_sel, 0);
        idle();
        tick();
        chk("fl_done_late", md_done, 0);
        tick();
        chk("fl_done_late2", md_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
